// File: rtl/envio_serial_parametrizado_if.sv
// Signal bundle between the serial dump engine, the elevator content/queue RAMs and the UART line.
interface envio_serial_parametrizado_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned W_CONT = 4,
    parameter int unsigned W_FILA = 6
);
    logic              mudou_de_andar;
    logic [W_CONT-1:0] dados_conteudo_elevador;
    logic [W_FILA-1:0] dados_fila_elevador;
    logic              eh_origem_fila_elevador;
    logic [ADDR_W-1:0] addr_conteudo_elevador;
    logic [ADDR_W-1:0] addr_fila_elevador;
    logic              TX;
    logic              busy;
    logic              done;

    modport master (
        input  mudou_de_andar, dados_conteudo_elevador, dados_fila_elevador,
               eh_origem_fila_elevador,
        output addr_conteudo_elevador, addr_fila_elevador, TX, busy, done
    );

    modport slave (
        output mudou_de_andar, dados_conteudo_elevador, dados_fila_elevador,
               eh_origem_fila_elevador,
        input  addr_conteudo_elevador, addr_fila_elevador, TX, busy, done
    );
endinterface

// File: rtl/envio_serial_parametrizado.sv
// Serial dump engine: on a floor-change edge, scans content RAM then queue RAM and sends 8N1 bytes.
// Define ENVIO_CHECKSUM_EN to append an XOR checksum byte before the terminator.
module envio_serial_parametrizado #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH_CONT   = 8,
    parameter int unsigned DEPTH_FILA   = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned W_CONT       = 4,
    parameter int unsigned W_FILA       = 6,
    parameter int unsigned SKIP_EMPTY   = 0,
    parameter logic [7:0]  HEADER_BYTE  = 8'h23,
    parameter logic [7:0]  TERM_BYTE    = 8'h0A
) (
    input  logic clock,
    input  logic reset,
    envio_serial_parametrizado_if.master bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_C_ADDR, S_C_READ, S_C_SEND, S_F_ADDR, S_F_READ, S_F_SEND,
`ifdef ENVIO_CHECKSUM_EN
        S_CSUM,
`endif
        S_TERM, S_FIN
    } state_t;

`ifdef ENVIO_CHECKSUM_EN
    localparam state_t S_AFTER_FILA = S_CSUM;
`else
    localparam state_t S_AFTER_FILA = S_TERM;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_c, addr_c_n, addr_f, addr_f_n;
    logic [7:0]        byte_q, byte_n;
    logic              trig_prev, trig_edge, pending;
    logic              c_last, f_last, c_empty, f_empty;
    logic              fin_done, restart;
    logic              tx_start, tx_ready;
    logic [7:0]        tx_data;
    logic              tx_active, tx_line;
    logic [8:0]        tx_shift;
    logic [3:0]        tx_bit;
    logic [CNT_W-1:0]  tx_cnt;
`ifdef ENVIO_CHECKSUM_EN
    logic [7:0]        csum, csum_n;
`endif

    assign trig_edge = bus.mudou_de_andar & ~trig_prev;
    assign tx_ready  = ~tx_active;
    assign c_last    = (addr_c == ADDR_W'(DEPTH_CONT - 1));
    assign f_last    = (addr_f == ADDR_W'(DEPTH_FILA - 1));
    // Queue emptiness looks at data only; the origin flag never keeps an entry alive.
    assign c_empty   = (SKIP_EMPTY != 0) && (bus.dados_conteudo_elevador == '0);
    assign f_empty   = (SKIP_EMPTY != 0) && (bus.dados_fila_elevador == '0);

    always_comb begin
        state_n  = state;
        addr_c_n = addr_c;
        addr_f_n = addr_f;
        byte_n   = byte_q;
        tx_start = 1'b0;
        tx_data  = byte_q;
        fin_done = 1'b0;
        restart  = 1'b0;
`ifdef ENVIO_CHECKSUM_EN
        csum_n   = csum;
`endif
        case (state)
            S_IDLE: if (trig_edge) state_n = S_HDR;
            S_HDR: if (tx_ready) begin
                tx_start = 1'b1;
                tx_data  = HEADER_BYTE;
`ifdef ENVIO_CHECKSUM_EN
                csum_n   = HEADER_BYTE;
`endif
                state_n  = S_C_ADDR;
            end
            S_C_ADDR: state_n = S_C_READ;
            S_C_READ: begin
                byte_n = {2'b00, 6'(bus.dados_conteudo_elevador)};
                if (c_empty) begin
                    addr_c_n = c_last ? '0 : addr_c + ADDR_W'(1);
                    state_n  = c_last ? S_F_ADDR : S_C_ADDR;
                end else begin
                    state_n  = S_C_SEND;
                end
            end
            S_C_SEND: if (tx_ready) begin
                tx_start = 1'b1;
`ifdef ENVIO_CHECKSUM_EN
                csum_n   = csum ^ byte_q;
`endif
                addr_c_n = c_last ? '0 : addr_c + ADDR_W'(1);
                state_n  = c_last ? S_F_ADDR : S_C_ADDR;
            end
            S_F_ADDR: state_n = S_F_READ;
            S_F_READ: begin
                byte_n = {1'b1, bus.eh_origem_fila_elevador, 6'(bus.dados_fila_elevador)};
                if (f_empty) begin
                    addr_f_n = f_last ? '0 : addr_f + ADDR_W'(1);
                    state_n  = f_last ? S_AFTER_FILA : S_F_ADDR;
                end else begin
                    state_n  = S_F_SEND;
                end
            end
            S_F_SEND: if (tx_ready) begin
                tx_start = 1'b1;
`ifdef ENVIO_CHECKSUM_EN
                csum_n   = csum ^ byte_q;
`endif
                addr_f_n = f_last ? '0 : addr_f + ADDR_W'(1);
                state_n  = f_last ? S_AFTER_FILA : S_F_ADDR;
            end
`ifdef ENVIO_CHECKSUM_EN
            S_CSUM: if (tx_ready) begin
                tx_start = 1'b1;
                tx_data  = csum;
                state_n  = S_TERM;
            end
`endif
            S_TERM: if (tx_ready) begin
                tx_start = 1'b1;
                tx_data  = TERM_BYTE;
                state_n  = S_FIN;
            end
            S_FIN: begin
                addr_c_n = '0;
                addr_f_n = '0;
                // An edge landing on the done cycle counts as a queued retrigger.
                if (tx_ready) begin
                    fin_done = 1'b1;
                    restart  = pending | trig_edge;
                    state_n  = restart ? S_HDR : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_c    <= '0;
            addr_f    <= '0;
            byte_q    <= '0;
            pending   <= 1'b0;
            trig_prev <= bus.mudou_de_andar;
`ifdef ENVIO_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            addr_c    <= addr_c_n;
            addr_f    <= addr_f_n;
            byte_q    <= byte_n;
            trig_prev <= bus.mudou_de_andar;
`ifdef ENVIO_CHECKSUM_EN
            csum      <= csum_n;
`endif
            if (fin_done)
                pending <= 1'b0;
            else if (trig_edge && state != S_IDLE)
                pending <= 1'b1;
        end
    end

    // Shift register holds data bits then the stop bit; ones shift in behind it.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_active <= 1'b0;
            tx_line   <= 1'b1;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (tx_start) begin
            tx_active <= 1'b1;
            tx_line   <= 1'b0;
            tx_shift  <= {1'b1, tx_data};
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (tx_active) begin
            if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.addr_conteudo_elevador = addr_c;
    assign bus.addr_fila_elevador     = addr_f;
    assign bus.TX                     = tx_line;
    assign bus.done                   = fin_done;
    assign bus.busy                   = (state != S_IDLE) && !(fin_done && !restart);
endmodule

// File: tb/tb_envio_serial_parametrizado.sv
// Directed bench: two engine instances (no skip / skip empty) at 4 clocks per bit, UART decoded back to bytes.
module tb_envio_serial_parametrizado;
`ifdef ENVIO_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic trig0, trig1;
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    envio_serial_parametrizado_if #(.ADDR_W(4), .W_CONT(4), .W_FILA(6)) if0 ();
    envio_serial_parametrizado_if #(.ADDR_W(4), .W_CONT(4), .W_FILA(6)) if1 ();

    envio_serial_parametrizado #(.CLKS_PER_BIT(4), .SKIP_EMPTY(0)) u_dut (
        .clock(clk), .reset(reset), .bus(if0));
    envio_serial_parametrizado #(.CLKS_PER_BIT(4), .SKIP_EMPTY(1)) u_skip (
        .clock(clk), .reset(reset), .bus(if1));

    logic [3:0] cont0 [16];
    logic [3:0] cont1 [16];
    logic [5:0] fila0 [16];
    logic [5:0] fila1 [16];
    logic       orig  [16];

    assign if0.mudou_de_andar          = trig0;
    assign if0.dados_conteudo_elevador = cont0[if0.addr_conteudo_elevador];
    assign if0.dados_fila_elevador     = fila0[if0.addr_fila_elevador];
    assign if0.eh_origem_fila_elevador = orig[if0.addr_fila_elevador];
    assign if1.mudou_de_andar          = trig1;
    assign if1.dados_conteudo_elevador = cont1[if1.addr_conteudo_elevador];
    assign if1.dados_fila_elevador     = fila1[if1.addr_fila_elevador];
    assign if1.eh_origem_fila_elevador = orig[if1.addr_fila_elevador];

    logic [7:0] rx0[$], rx1[$], exp_q[$];
    bit         tm0[$], tm1[$];
    int         st0[$], st1[$];
    int         done0 = 0, done1 = 0, falls0 = 0, addr_bad = 0, quiet_bad = 0;
    logic       busy_prev0 = 1'b0;
    bit         quiet = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel != 0) ? if1.TX : if0.TX;
    endfunction

    // Samples 40 consecutive clocks from the first low sample; every bit must hold for 4 clocks.
    task automatic grab_frame(input int sel, output logic [7:0] b, output bit ok);
        logic [39:0] s;
        s[0] = tx_of(sel);
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            s[i] = tx_of(sel);
        end
        ok = (s[0] === 1'b0) && (s[36] === 1'b1);
        for (int k = 0; k < 10; k++)
            for (int j = 1; j < 4; j++)
                if (s[4*k+j] !== s[4*k]) ok = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = s[4*k+4];
    endtask

    initial begin : dec0
        logic [7:0] b;
        bit ok;
        forever begin
            @(negedge clk);
            if (if0.TX === 1'b0) begin
                st0.push_back(cyc);
                grab_frame(0, b, ok);
                rx0.push_back(b);
                tm0.push_back(ok);
            end
        end
    end

    initial begin : dec1
        logic [7:0] b;
        bit ok;
        forever begin
            @(negedge clk);
            if (if1.TX === 1'b0) begin
                st1.push_back(cyc);
                grab_frame(1, b, ok);
                rx1.push_back(b);
                tm1.push_back(ok);
            end
        end
    end

    always @(negedge clk) begin
        if (if0.done === 1'b1) done0 <= done0 + 1;
        if (if1.done === 1'b1) done1 <= done1 + 1;
        if (busy_prev0 === 1'b1 && if0.busy === 1'b0) falls0 <= falls0 + 1;
        busy_prev0 <= if0.busy;
        if (if0.addr_conteudo_elevador != 4'd0 && if0.addr_fila_elevador != 4'd0)
            addr_bad <= addr_bad + 1;
        if (quiet && (if0.TX !== 1'b1 || if0.busy !== 1'b0 || if1.TX !== 1'b1 || if1.busy !== 1'b0))
            quiet_bad <= quiet_bad + 1;
    end

    task automatic build_exp(input int sel);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'h23);
        for (int i = 0; i < 8; i++) begin
            x = {4'h0, (sel != 0) ? cont1[i] : cont0[i]};
            if (!(sel != 0 && x == 8'h00)) exp_q.push_back(x);
        end
        for (int j = 0; j < 16; j++) begin
            x = {1'b1, orig[j], (sel != 0) ? fila1[j] : fila0[j]};
            if (!(sel != 0 && x[5:0] == 6'd0)) exp_q.push_back(x);
        end
`ifdef ENVIO_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_done(input int sel, input int target, input int budget);
        int n = 0;
        while (((sel != 0) ? done1 : done0) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_done", 32'(((sel != 0) ? done1 : done0) >= target), 32'd1);
    endtask

    task automatic clear_rx();
        rx0.delete(); rx1.delete(); tm0.delete(); tm1.delete(); st0.delete(); st1.delete();
    endtask

    task automatic check_dump0(input string tag, input int base);
        int bad = 0;
        for (int i = 0; i < 26 + CS; i++)
            if (base + i < rx0.size() && rx0[base+i] !== exp_q[i]) bad++;
        check_eq(tag, 32'(bad), 32'd0);
    endtask

    task automatic edge0();
        trig0 = 1'b0;
        @(negedge clk);
        trig0 = 1'b1;
    endtask

    initial begin
        int d0, f0, n, bad;
        logic [7:0] x;
        for (int i = 0; i < 16; i++) begin
            cont0[i] = {2'(i), 2'(i + 1)};
            cont1[i] = (i == 2 || i == 5) ? 4'h0 : cont0[i];
            fila0[i] = 6'(i + 1);
            fila1[i] = (i >= 8) ? 6'd0 : 6'(i + 1);
            orig[i]  = 1'(i);
        end
        reset = 1'b1;
        trig0 = 1'b1;
        trig1 = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_tx", 32'(if0.TX), 32'd1);
        check_eq("rst_busy", 32'(if0.busy), 32'd0);
        check_eq("rst_done", 32'(if0.done), 32'd0);
        check_eq("rst_addr_c", 32'(if0.addr_conteudo_elevador), 32'd0);
        check_eq("rst_addr_f", 32'(if0.addr_fila_elevador), 32'd0);

        // Trigger held high across reset release must not start a dump.
        reset = 1'b0;
        quiet = 1'b1;
        repeat (1000) @(negedge clk);
        quiet = 1'b0;
        check_eq("quiet_violations", 32'(quiet_bad), 32'd0);
        check_eq("quiet_frames", 32'(rx0.size() + rx1.size()), 32'd0);

        // Full dump, no skipping
        build_exp(0);
        trig0 = 1'b0;
        @(negedge clk);
        check_eq("busy_pre", 32'(if0.busy), 32'd0);
        trig0 = 1'b1;
        @(negedge clk);
        check_eq("busy_rise", 32'(if0.busy), 32'd1);
        wait_done(0, 1, 3000);
        repeat (20) @(negedge clk);
        check_eq("dump_len", 32'(rx0.size()), 32'(26 + CS));
        if (rx0.size() >= 11) begin
            check_eq("hdr", 32'(rx0[0]), 32'h23);
            check_eq("cont0", 32'(rx0[1]), 32'h01);
            check_eq("cont1", 32'(rx0[2]), 32'h06);
            check_eq("cont2", 32'(rx0[3]), 32'h0B);
            check_eq("cont3", 32'(rx0[4]), 32'h0C);
            check_eq("fila0", 32'(rx0[9]), 32'h81);
            check_eq("fila1", 32'(rx0[10]), 32'hC2);
        end
        if (rx0.size() > 0) check_eq("term", 32'(rx0[rx0.size()-1]), 32'h0A);
        check_dump0("dump_bytes", 0);
`ifdef ENVIO_CHECKSUM_EN
        if (rx0.size() >= 26) begin
            x = 8'h00;
            for (int i = 0; i < 25; i++) x = x ^ rx0[i];
            check_eq("csum_byte", 32'(rx0[25]), 32'(x));
        end
`endif
        bad = 0;
        foreach (tm0[i]) if (!tm0[i]) bad++;
        check_eq("bit_timing", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < st0.size(); i++)
            if (st0[i] - st0[i-1] < 40 || st0[i] - st0[i-1] > 43) bad++;
        check_eq("frame_gap", 32'(bad), 32'd0);
        check_eq("done_once", 32'(done0), 32'd1);
        check_eq("busy_end", 32'(if0.busy), 32'd0);
        check_eq("addr_exclusive", 32'(addr_bad), 32'd0);
        check_eq("addr_c_end", 32'(if0.addr_conteudo_elevador), 32'd0);

        // Skip-empty instance
        clear_rx();
        build_exp(1);
        trig1 = 1'b0;
        @(negedge clk);
        trig1 = 1'b1;
        wait_done(1, 1, 3000);
        repeat (20) @(negedge clk);
        check_eq("skip_len", 32'(rx1.size()), 32'(16 + CS));
        bad = 0;
        foreach (exp_q[i]) if (i < rx1.size() && rx1[i] !== exp_q[i]) bad++;
        check_eq("skip_bytes", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i <= 14 && i < rx1.size(); i++)
            if (rx1[i] == 8'h00 || rx1[i] == 8'h80 || rx1[i] == 8'hC0) bad++;
        check_eq("skip_no_empty", 32'(bad), 32'd0);

        // Retrigger while busy: exactly one queued dump
        clear_rx();
        build_exp(0);
        d0 = done0;
        f0 = falls0;
        edge0();
        n = 0;
        while (rx0.size() < 3 && n < 2000) begin @(negedge clk); n++; end
        check_eq("retrig_start", 32'(rx0.size() >= 3), 32'd1);
        for (int k = 0; k < 3; k++) begin
            trig0 = 1'b0;
            repeat (2) @(negedge clk);
            trig0 = 1'b1;
            repeat (2) @(negedge clk);
        end
        wait_done(0, d0 + 2, 6000);
        repeat (200) @(negedge clk);
        check_eq("retrig_len", 32'(rx0.size()), 32'(2 * (26 + CS)));
        check_dump0("retrig_first", 0);
        check_dump0("retrig_second", 26 + CS);
        check_eq("retrig_done", 32'(done0 - d0), 32'd2);
        check_eq("retrig_busy_falls", 32'(falls0 - f0), 32'd1);

        // Reset during the 5th frame
        clear_rx();
        d0 = done0;
        edge0();
        n = 0;
        while (st0.size() < 5 && n < 2000) begin @(negedge clk); n++; end
        check_eq("frame5_seen", 32'(st0.size() >= 5), 32'd1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_tx", 32'(if0.TX), 32'd1);
        check_eq("abort_busy", 32'(if0.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("abort_no_done", 32'(done0), 32'(d0));
        clear_rx();
        edge0();
        wait_done(0, d0 + 1, 3000);
        repeat (20) @(negedge clk);
        check_eq("post_abort_len", 32'(rx0.size()), 32'(26 + CS));
        check_dump0("post_abort_bytes", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/envio_serial_parametrizado.md
Name: envio_serial_parametrizado

Overview:
- Parametrised successor to the automatic serial dump engine.
- On each floor-change event it scans the elevator-content RAM, then the elevator-queue RAM, and encodes each entry as one byte.
- Bytes go out on TX as 8N1 UART frames, wrapped by a header byte and a terminator byte.
- Adds edge-triggered start, retrigger queuing, optional empty-entry skipping, a busy/done handshake and configurable depths, widths and baud.

Parameters:
- CLKS_PER_BIT, 434, clocks per UART bit; must be ≥2.
- DEPTH_CONT, 8, number of content-RAM entries scanned (1..2^ADDR_W).
- DEPTH_FILA, 16, number of queue-RAM entries scanned (1..2^ADDR_W).
- ADDR_W, 4, width of both RAM address outputs.
- W_CONT, 4, content data width (≤6).
- W_FILA, 6, queue data width (≤6).
- SKIP_EMPTY, 0, when 1 the engine omits entries whose data is all zero.
- HEADER_BYTE, 8'h23, first byte of every dump.
- TERM_BYTE, 8'h0A, last byte of every dump.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mudou_de_andar  in  1  trigger; a rising edge starts a dump
- dados_conteudo_elevador  in  W_CONT  content RAM read data
- dados_fila_elevador  in  W_FILA  queue RAM read data
- eh_origem_fila_elevador  in  1  queue entry flag (origin pending)
- addr_conteudo_elevador  out  ADDR_W  content RAM read address
- addr_fila_elevador  out  ADDR_W  queue RAM read address
- TX  out  1  UART line, idle high
- busy  out  1  high from dump start until the terminator stop bit ends
- done  out  1  one-clock pulse after the terminator stop bit

Behaviour:
- Reset (synchronous, active-high; one clock, one reset, as fixed for this block):
  - TX=1, busy=0, done=0, both addresses=0.
  - Edge register cleared to the current mudou_de_andar value, so a level already high at reset release does not trigger.
  - Pending flag cleared.
  - Reset mid-dump aborts the dump immediately; TX returns high on the next edge.
- Trigger:
  - Edge detect is prev=0, now=1, sampled on clock.
  - In IDLE, busy rises the clock after the edge.
  - An edge while busy sets pending; further edges while pending are absorbed (at most one queued dump).
  - At done, if pending: clear it and restart directly, with busy held high and done still pulsing.
- FSM states: IDLE → HDR → C_ADDR → C_READ → C_SEND → (loop) → F_ADDR → F_READ → F_SEND → (loop) → [CSUM] → TERM → FIN → IDLE.
- Read timing: the address is driven in *_ADDR; data is sampled at the end of *_READ, one clock later. This tolerates both combinational-read and registered-read RAMs.
- Byte encoding:
  - Content entry: {1'b0, 1'b0, data zero-extended to 6}.
  - Queue entry: {1'b1, eh_origem, data zero-extended to 6}.
- SKIP_EMPTY=1: an entry whose data is all zero is not sent.
  - The content check uses data only.
  - The queue check ignores eh_origem.
- Address sequencing:
  - Content addresses run 0..DEPTH_CONT-1, queue addresses 0..DEPTH_FILA-1.
  - Both outputs return to 0 in FIN.
  - The unused address holds 0 while the other RAM is scanned.
- UART transmitter:
  - Frame: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts exactly CLKS_PER_BIT clocks.
  - Gap between a stop bit's end and the next start bit: ≤3 clocks, plus ≤2 clocks for each skipped entry.
- Dump length in bytes: 2 + sent entries (+1 with the optional feature).
  - Default parameters, no skipping: 26 bytes.

Optional Feature:
- Macro: ENVIO_CHECKSUM_EN.
- Defined: the CSUM state sends one extra byte, the XOR of every byte from the header through the last entry byte, immediately before TERM_BYTE.
- Undefined: the CSUM state and XOR register are absent; TERM follows the last entry directly.

Test Plan:
- Reset hold, then release with mudou_de_andar=1 held → no dump; TX=1, busy=0 for 1000 clocks.
- CLKS_PER_BIT=4, defaults, content[i]={i[1:0],(i+1)[1:0]}, queue RAM filled; 0→1 edge → 26 frames decode as:
  - 0x23;
  - content bytes 0x01, 0x06, 0x0B, 0x0C…;
  - queue bytes with bit7=1;
  - 0x0A;
  - then done pulses once and busy falls.
- Bit timing: measure the first start bit → TX low for exactly 4 clocks; every bit spans 4 clocks; gap ≤3 clocks.
- SKIP_EMPTY=1 with content entries 2 and 5 = 0 and queue entries 8..15 = 0 → 16 bytes total; no 0x00 or 0x80/0xC0 entry bytes.
- Three extra edges mid-dump → exactly two complete dumps back-to-back; busy never drops between them; done pulses twice.
- Reset asserted during the 5th frame → TX=1 the next clock, busy=0, no done pulse; a later edge yields a full, correct dump.
- With ENVIO_CHECKSUM_EN defined → 27 bytes; byte 26 equals the XOR of bytes 1..25.
